// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

  localparam int FETCH_XLEN = 32;
  localparam int INST_BYTES = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_if.sv
// rtl/ifetch_if.sv - redirect, memory-read and decode-side signals of the fetch stage
interface ifetch_if #(
  parameter int XLEN = 32
);
  logic            redirectValid;
  logic [XLEN-1:0] redirectPc;
  logic            memReqValid;
  logic [XLEN-1:0] memAddr;
  logic            memBusy;
  logic            memRespValid;
  logic [XLEN-1:0] memRdata;
  logic            instValid;
  logic [XLEN-1:0] instData;
  logic [XLEN-1:0] instPc;
  logic            instReady;

  modport master (
    input  redirectValid, redirectPc, memBusy, memRespValid, memRdata, instReady,
    output memReqValid, memAddr, instValid, instData, instPc
  );

  modport slave (
    output redirectValid, redirectPc, memBusy, memRespValid, memRdata, instReady,
    input  memReqValid, memAddr, instValid, instData, instPc
  );
endinterface

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - small synchronous FIFO of fetched {pc, inst} entries
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [AW:0]  count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Entries are cleared on reset so the head reads as zero before the first push.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  assert property (@(posedge clock) disable iff (!reset) !(push && !flush && count == FULL))
    else $error("fetch_buf: push while full");

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - fetch PC, single-outstanding read FSM and decode-facing buffer
module ifetch
  import fetch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 'h8000_0000,
  parameter int              BUF_DEPTH = 2
) (
  input logic     clock,
  input logic     reset,
  ifetch_if.master bus
);

  localparam int            CW       = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] BUF_FULL = CW'(BUF_DEPTH);

  fetch_state_e    state, state_nx;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   count;
  fetch_entry_t    head, push_entry;
  logic            issue, push, pop;

  assign issue = (state == S_IDLE) && !bus.memBusy && (count < BUF_FULL) && !bus.redirectValid;
  // memAddr still holds the address of the outstanding read, so it tags the returned word.
  assign push  = (state == S_WAIT) && bus.memRespValid && !bus.redirectValid;
  assign pop   = bus.instValid && bus.instReady && !bus.redirectValid;
  assign push_entry = '{pc: bus.memAddr, inst: bus.memRdata};

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (issue) state_nx = S_WAIT;
      S_WAIT: begin
        if (bus.memRespValid)       state_nx = S_IDLE;
        else if (bus.redirectValid) state_nx = S_DROP;
      end
      S_DROP:  if (bus.memRespValid) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      fetch_pc        <= RESET_PC;
      bus.memReqValid <= 1'b0;
      bus.memAddr     <= '0;
    end else begin
      state           <= state_nx;
      bus.memReqValid <= issue;
      if (issue) bus.memAddr <= fetch_pc;
      if (bus.redirectValid)
        fetch_pc <= bus.redirectPc & ~XLEN'(INST_BYTES - 1);
      else if (issue)
        fetch_pc <= fetch_pc + XLEN'(INST_BYTES);
    end
  end

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (bus.redirectValid),
    .head       (head),
    .count      (count)
  );

  assign bus.instValid = (count != '0);
  assign bus.instData  = head.inst;
  assign bus.instPc    = head.pc;

  assert property (@(posedge clock) disable iff (!reset) !(state == S_IDLE && bus.memRespValid))
    else $error("ifetch: memRespValid with no outstanding read");

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - directed bench for ifetch with a behavioural mread model
module tb_ifetch;

  logic clock;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   lat    = 5;
  int   m_cnt;
  logic [31:0] m_addr;
  logic [31:0] issued [$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  ifetch_if #(.XLEN(32)) bus ();

  ifetch #(.XLEN(32), .RESET_PC(32'h8000_0000), .BUF_DEPTH(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_inst(input string tag, input logic [31:0] pc, input logic [31:0] data);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!bus.instValid && n < 60);
    check({tag, "_valid"}, {31'd0, bus.instValid}, 32'd1);
    check({tag, "_pc"}, bus.instPc, pc);
    check({tag, "_data"}, bus.instData, data);
  endtask

  task automatic do_reset();
    reset             = 1'b0;
    bus.instReady     = 1'b0;
    bus.redirectValid = 1'b0;
    bus.redirectPc    = '0;
    repeat (2) tick();
    issued.delete();
    reset = 1'b1;
  endtask

  // mread model: captures a request, answers ~addr after lat cycles, shares the reset.
  initial begin
    bus.memBusy      = 1'b0;
    bus.memRespValid = 1'b0;
    bus.memRdata     = '0;
    m_cnt            = 0;
    m_addr           = '0;
    forever begin
      @(negedge clock);
      bus.memRespValid = 1'b0;
      if (!reset) begin
        bus.memBusy = 1'b0;
        m_cnt       = 0;
      end else if (bus.memReqValid) begin
        check("one_outstanding", {31'd0, bus.memBusy}, 32'd0);
        issued.push_back(bus.memAddr);
        m_addr      = bus.memAddr;
        m_cnt       = lat;
        bus.memBusy = 1'b1;
      end else if (bus.memBusy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          bus.memRespValid = 1'b1;
          bus.memRdata     = ~m_addr;
          bus.memBusy      = 1'b0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset             = 1'b0;
    bus.instReady     = 1'b0;
    bus.redirectValid = 1'b0;
    bus.redirectPc    = '0;
    repeat (2) tick();
    check("rst_reqvalid", {31'd0, bus.memReqValid}, 32'd0);
    check("rst_addr", bus.memAddr, 32'd0);
    check("rst_instvalid", {31'd0, bus.instValid}, 32'd0);
    check("rst_instdata", bus.instData, 32'd0);
    check("rst_instpc", bus.instPc, 32'd0);

    // Streaming fetch with decode always ready
    reset         = 1'b1;
    bus.instReady = 1'b1;
    wait_inst("t1_e0", 32'h8000_0000, 32'h7FFF_FFFF);
    wait_inst("t1_e1", 32'h8000_0004, 32'h7FFF_FFFB);
    wait_inst("t1_e2", 32'h8000_0008, 32'h7FFF_FFF7);
    check("t1_issue0", issued[0], 32'h8000_0000);
    check("t1_issue1", issued[1], 32'h8000_0004);

    // Decode stalled: buffer fills to two entries and issue stops
    do_reset();
    repeat (30) tick();
    check("t2_nissued", issued.size(), 32'd2);
    check("t2_issue0", issued[0], 32'h8000_0000);
    check("t2_issue1", issued[1], 32'h8000_0004);
    check("t2_reqvalid", {31'd0, bus.memReqValid}, 32'd0);
    check("t2_head_valid", {31'd0, bus.instValid}, 32'd1);
    check("t2_head_pc", bus.instPc, 32'h8000_0000);
    check("t2_head_data", bus.instData, 32'h7FFF_FFFF);
    bus.instReady = 1'b1;
    wait_inst("t2_e1", 32'h8000_0004, 32'h7FFF_FFFB);
    wait_inst("t2_e2", 32'h8000_0008, 32'h7FFF_FFF7);
    check("t2_issue2", issued[2], 32'h8000_0008);

    // Redirect two cycles after the 0x8000_0004 issue drops that response
    do_reset();
    bus.instReady = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(bus.memReqValid && bus.memAddr == 32'h8000_0004) && n < 60);
    check("t3_issue4", bus.memAddr, 32'h8000_0004);
    tick();
    bus.redirectValid = 1'b1;
    bus.redirectPc    = 32'h8000_0102;
    tick();
    bus.redirectValid = 1'b0;
    check("t3_flushed", {31'd0, bus.instValid}, 32'd0);
    wait_inst("t3_e0", 32'h8000_0100, 32'h7FFF_FEFF);
    check("t3_issue_redir", issued[2], 32'h8000_0100);

    // Redirect coinciding with the response in S_WAIT
    do_reset();
    bus.instReady = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.memRespValid && n < 60);
    check("t4_resp_seen", {31'd0, bus.memRespValid}, 32'd1);
    bus.redirectValid = 1'b1;
    bus.redirectPc    = 32'h8000_0200;
    tick();
    bus.redirectValid = 1'b0;
    check("t4_no_push", {31'd0, bus.instValid}, 32'd0);
    check("t4_no_issue", {31'd0, bus.memReqValid}, 32'd0);
    tick();
    check("t4_issue_valid", {31'd0, bus.memReqValid}, 32'd1);
    check("t4_issue_addr", bus.memAddr, 32'h8000_0200);
    wait_inst("t4_e0", 32'h8000_0200, 32'h7FFF_FDFF);

    // PC wrap at 0xFFFF_FFFC and simultaneous push/pop at count=1
    do_reset();
    bus.redirectValid = 1'b1;
    bus.redirectPc    = 32'hFFFF_FFFE;
    tick();
    bus.redirectValid = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(bus.memRespValid && bus.memAddr == 32'h0000_0000) && n < 60);
    check("t5_head_valid", {31'd0, bus.instValid}, 32'd1);
    check("t5_head_pc", bus.instPc, 32'hFFFF_FFFC);
    check("t5_head_data", bus.instData, 32'h0000_0003);
    bus.instReady = 1'b1;
    tick();
    check("t5_pp_valid", {31'd0, bus.instValid}, 32'd1);
    check("t5_pp_pc", bus.instPc, 32'h0000_0000);
    check("t5_pp_data", bus.instData, 32'hFFFF_FFFF);
    tick();
    check("t5_drained", {31'd0, bus.instValid}, 32'd0);
    check("t5_issue0", issued[0], 32'hFFFF_FFFC);
    check("t5_issue1", issued[1], 32'h0000_0000);

    // Asynchronous reset while a read is outstanding
    do_reset();
    n = 0;
    do begin
      tick();
      n++;
    end while (!(bus.memReqValid && bus.memAddr == 32'h8000_0004) && n < 60);
    tick();
    check("t6_pre_valid", {31'd0, bus.instValid}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("t6_rst_reqvalid", {31'd0, bus.memReqValid}, 32'd0);
    check("t6_rst_addr", bus.memAddr, 32'd0);
    check("t6_rst_instvalid", {31'd0, bus.instValid}, 32'd0);
    check("t6_rst_instpc", bus.instPc, 32'd0);
    check("t6_rst_instdata", bus.instData, 32'd0);
    repeat (2) tick();
    issued.delete();
    reset         = 1'b1;
    bus.instReady = 1'b1;
    wait_inst("t6_e0", 32'h8000_0000, 32'h7FFF_FFFF);
    check("t6_issue0", issued[0], 32'h8000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
